// File: rtl/simpledev_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : simpledev_bus_master
// Description : Bus initiator for the simpledev register interface. Commands
//               are queued in a small FIFO and played out as
//               SETUP / STROBE / WAIT / GAP accesses on the device pins.
//               Read data and feedback are returned as one-cycle responses.
// Ports       : clk, rst_n (async, active-low)
//               cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data : command in
//               bus_address/bus_data/bus_accessType/bus_ready    : device bus
//               dev_rdata/dev_feedback                           : device return
//               rsp_valid/rsp_data/rsp_feedback                  : response out
//               err_misalign, busy                               : status
// Options     : SIMPLEDEV_MASTER_FEEDBACK_EN - writes also respond and
//               rsp_feedback carries dev_feedback captured for every access.
// Revision    : 1.0 - initial release
// ============================================================================
module simpledev_bus_master #(
    parameter int DEPTH  = 4,
    parameter int GAP    = 1,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic [31:0] bus_address,
    output logic [31:0] bus_data,
    output logic        bus_accessType,
    output logic        bus_ready,
    input  logic [31:0] dev_rdata,
    input  logic [3:0]  dev_feedback,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_feedback,
    output logic        err_misalign,
    output logic        busy
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = 16;
    localparam int c_ENT_W = 65;
    localparam logic [c_CNT_W-1:0] c_RD_LAST  = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t r_state, w_state_nx;

    // FIFO entry layout: {write, addr[31:0], data[31:0]}
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]   r_count, w_count_nx;
    logic               r_cmd_ready;
    logic               w_accept, w_push, w_pop, w_empty;
    logic [c_ENT_W-1:0] w_head;

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_cnt_clr, w_capture;

    logic [31:0]        r_bus_address, r_bus_data;
    logic               r_bus_write;
    logic               r_rsp_valid, r_err_misalign;
    logic [31:0]        r_rsp_data;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_push     = w_accept && (cmd_addr[1:0] == 2'b00);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_count_nx = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data};
        end
    end

    // cmd_ready is registered from the occupancy after this cycle's
    // push/pop, so a pop in the cycle the FIFO is full does not free a slot
    // until the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_cmd_ready    <= 1'b1;
            r_err_misalign <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count        <= w_count_nx;
            r_cmd_ready    <= (w_count_nx != c_DEPTH);
            r_err_misalign <= w_accept && (cmd_addr[1:0] != 2'b00);
        end
    end

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_cnt_clr  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nx = S_STROBE;
            end
            S_STROBE: begin
                w_cnt_clr  = 1'b1;
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                // Writes wait a single cycle; reads wait RD_LAT cycles.
                if (r_bus_write ? (r_cnt == '0) : (r_cnt == c_RD_LAST)) begin
                    w_capture  = 1'b1;
                    w_cnt_clr  = 1'b1;
                    w_state_nx = (GAP == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_bus_address <= '0;
            r_bus_data    <= '0;
            r_bus_write   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + c_CNT_W'(1);
            if (w_pop) begin
                r_bus_write   <= w_head[64];
                r_bus_address <= w_head[63:32];
                r_bus_data    <= w_head[64] ? w_head[31:0] : 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------
`ifdef SIMPLEDEV_MASTER_FEEDBACK_EN
    logic [3:0] r_rsp_feedback;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_feedback <= '0;
        end else begin
            r_rsp_valid <= w_capture;
            if (w_capture) begin
                r_rsp_data     <= r_bus_write ? 32'h0 : dev_rdata;
                r_rsp_feedback <= dev_feedback;
            end
        end
    end

    assign rsp_feedback = r_rsp_feedback;
`else
    logic w_unused_feedback;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_capture && !r_bus_write;
            if (w_capture && !r_bus_write) begin
                r_rsp_data <= dev_rdata;
            end
        end
    end

    assign w_unused_feedback = ^dev_feedback;
    assign rsp_feedback      = 4'h0;
`endif

    assign cmd_ready      = r_cmd_ready;
    assign bus_address    = r_bus_address;
    assign bus_data       = r_bus_data;
    assign bus_accessType = r_bus_write;
    assign bus_ready      = (r_state == S_STROBE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign err_misalign   = r_err_misalign;
    assign busy           = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simpledev_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_simpledev_bus_master
// Description : Directed self-checking bench for simpledev_bus_master
//               (DEPTH=4, GAP=1, RD_LAT=2). Honours
//               SIMPLEDEV_MASTER_FEEDBACK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simpledev_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] bus_address, bus_data;
    logic        bus_accessType, bus_ready;
    logic [31:0] dev_rdata = 32'hCAFE0001;
    logic [3:0]  dev_feedback = 4'hA;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_feedback;
    logic        err_misalign, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rsp = 0;
    logic [31:0] q_data[$];
    int          q_cyc[$];

    simpledev_bus_master #(.DEPTH(4), .GAP(1), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .bus_address(bus_address), .bus_data(bus_data),
        .bus_accessType(bus_accessType), .bus_ready(bus_ready),
        .dev_rdata(dev_rdata), .dev_feedback(dev_feedback),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_feedback(rsp_feedback),
        .err_misalign(err_misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and response log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_ready) begin
            q_data.push_back(bus_data);
            q_cyc.push_back(cyc);
        end
        if (rsp_valid) n_rsp <= n_rsp + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c0, base, nr;

        // ---------------- reset state ----------------
        tick(2);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bus_ready", {31'b0, bus_ready}, 32'd0);
        chk("rst_bus_address", bus_address, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_err", {31'b0, err_misalign}, 32'd0);
        chk("rst_rsp_feedback", {28'b0, rsp_feedback}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // ---------------- write 0x4 / 0x1 ----------------
        offer(1'b1, 32'h4, 32'h1);          // cycle T
        tick(1); cmd_valid = 1'b0;           // T+1
        chk("wr_t1_bus_ready", {31'b0, bus_ready}, 32'd0);
        chk("wr_t1_busy", {31'b0, busy}, 32'd1);
        tick(1);                             // T+2 SETUP
        chk("wr_setup_addr", bus_address, 32'h4);
        chk("wr_setup_data", bus_data, 32'h1);
        chk("wr_setup_type", {31'b0, bus_accessType}, 32'd1);
        chk("wr_setup_ready", {31'b0, bus_ready}, 32'd0);
        tick(1);                             // T+3 STROBE
        chk("wr_strobe", {31'b0, bus_ready}, 32'd1);
        tick(1);                             // T+4 WAIT
        chk("wr_wait_ready", {31'b0, bus_ready}, 32'd0);
        tick(1);                             // T+5 GAP
        chk("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("wr_gap_addr_held", bus_address, 32'h4);
        tick(1);                             // T+6 IDLE
        chk("wr_idle_busy", {31'b0, busy}, 32'd0);

        // ---------------- read 0x0 ----------------
        offer(1'b0, 32'h0, 32'h5555_5555);
        tick(1); cmd_valid = 1'b0;           // T+1
        tick(1);                             // T+2
        chk("rd_setup_type", {31'b0, bus_accessType}, 32'd0);
        chk("rd_setup_data0", bus_data, 32'h0);
        tick(3);                             // T+5
        chk("rd_t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
        tick(1);                             // T+6
        chk("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_rsp_data", rsp_data, 32'hCAFE0001);
        tick(1);                             // T+7
        chk("rd_rsp_pulse", {31'b0, rsp_valid}, 32'd0);
        chk("rd_rsp_hold", rsp_data, 32'hCAFE0001);
        tick(2);

        // ---------------- write 0x0 with feedback 0xA ----------------
        offer(1'b1, 32'h0, 32'h1234);
        tick(1); cmd_valid = 1'b0;
        tick(4);                             // T+5
`ifdef SIMPLEDEV_MASTER_FEEDBACK_EN
        chk("fb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("fb_rsp_feedback", {28'b0, rsp_feedback}, 32'hA);
        chk("fb_rsp_data", rsp_data, 32'h0);
`else
        chk("nofb_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("nofb_rsp_feedback", {28'b0, rsp_feedback}, 32'h0);
        chk("nofb_rsp_data_held", rsp_data, 32'hCAFE0001);
`endif
        tick(3);

        // ---------------- misaligned command ----------------
        base = q_data.size();
        offer(1'b1, 32'h6, 32'hDEAD);
        tick(1); cmd_valid = 1'b0;           // T+1
        chk("mis_err_pulse", {31'b0, err_misalign}, 32'd1);
        chk("mis_busy", {31'b0, busy}, 32'd0);
        tick(1);
        chk("mis_err_clear", {31'b0, err_misalign}, 32'd0);
        tick(6);
        chk("mis_no_strobe", q_data.size(), base);
        chk("mis_busy_late", {31'b0, busy}, 32'd0);

        // ---------------- five back-to-back writes ----------------
        base = q_data.size();
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("b2b_ready_3q", {31'b0, cmd_ready}, 32'd1);
            offer(1'b1, 32'h4, 32'h100 + i);
            tick(1);
        end
        chk("b2b_full_ready", {31'b0, cmd_ready}, 32'd0);   // T0+5
        cmd_valid = 1'b0;
        tick(20);                                            // T0+25 last GAP
        chk("b2b_busy_gap", {31'b0, busy}, 32'd1);
        tick(1);                                             // T0+26
        chk("b2b_busy_low", {31'b0, busy}, 32'd0);
        chk("b2b_strobe_cnt", q_data.size() - base, 32'd5);
        if (q_data.size() - base == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("b2b_data%0d", i), q_data[base + i], 32'h100 + i);
                chk($sformatf("b2b_cyc%0d", i), q_cyc[base + i] - c0, 32'(3 + 5 * i));
            end
        end
        tick(2);

        // ---------------- reset during STROBE ----------------
        offer(1'b0, 32'h0, 32'h0);           // T
        tick(1);
        offer(1'b1, 32'h4, 32'hAA);          // T+1
        tick(1);
        offer(1'b1, 32'h4, 32'hBB);          // T+2
        tick(1); cmd_valid = 1'b0;           // T+3 STROBE
        chk("arst_pre_strobe", {31'b0, bus_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_bus_ready", {31'b0, bus_ready}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        base = q_data.size();
        nr   = n_rsp;
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("arst_no_issue", q_data.size(), base);
        chk("arst_no_rsp", n_rsp, nr);
        chk("arst_idle_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
